bus_mem_responder: RTL and testbench

// - Memory-side responder for the HLS accelerator bus (V*_bus_* port set); the target end of an accelerator bus port.
// - Accepts read/write burst requests on the req channel and services them from an internal 128-bit word RAM.
// - Returns read data on datain and write acks through a response FIFO (rsp_dout/rsp_empty_n/rsp_read).
// - Replaces free-running stimulus sources on the datain side so accelerator tops close a real memory loop.

---
 rtl/bus_mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_bus_mem_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// Bus memory responder: services read/write bursts from an internal word RAM, responses via a small FIFO.
// Define BUS_MEM_RESPONDER_STATS_EN to add the stat_rd_beats/stat_wr_beats beat counters.
module bus_mem_responder #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              bus_req_din,
    input  logic              bus_req_write,
    output logic              bus_req_full_n,
    input  logic [31:0]       bus_address,
    input  logic [31:0]       bus_size,
    input  logic [DATA_W-1:0] bus_dataout,
    output logic [DATA_W-1:0] bus_datain,
    output logic              bus_rsp_empty_n,
    output logic              bus_rsp_dout,
    input  logic              bus_rsp_read
`ifdef BUS_MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]       stat_rd_beats,
    output logic [31:0]       stat_wr_beats
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned RW = $clog2(RSP_DEPTH);

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_ACK, RD_BURST} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [31:0]       size_q, size_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              alive_q;
    logic              hs;
    logic [31:0]       size_eff;

    logic              ram_we, ram_re;
    logic [AW-1:0]     ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q, rd_last_q, rd_last_d;

    logic [DATA_W-1:0] fifo_data_q [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] fifo_flag_q;
    logic [RW-1:0]     wptr_q, rptr_q;
    logic [RW:0]       count_q, free_slots;
    logic              push, pop, ack_push, fifo_full;
    logic              push_flag;
    logic [DATA_W-1:0] push_data;

    logic              unused_addr_bits;
    assign unused_addr_bits = ^{bus_address[31:AW+4], bus_address[3:0]};

    assign bus_req_full_n = alive_q && (state_q == IDLE || state_q == WR_DATA);
    assign hs             = bus_req_write && bus_req_full_n;
    assign size_eff       = (bus_size == 32'd0) ? 32'd1 : bus_size;
    assign fifo_full      = (count_q == (RW+1)'(RSP_DEPTH));
    assign free_slots     = (RW+1)'(RSP_DEPTH) - count_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        cnt_d     = cnt_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = addr_q + cnt_q[AW-1:0];
        ram_raddr = addr_q + cnt_q[AW-1:0];
        ack_push  = 1'b0;
        rd_last_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    addr_d = bus_address[AW+3:4];
                    size_d = size_eff;
                    if (bus_req_din) begin
                        ram_we    = 1'b1;
                        ram_waddr = bus_address[AW+3:4];
                        cnt_d     = 32'd1;
                        state_d   = (size_eff == 32'd1) ? WR_ACK : WR_DATA;
                    end else begin
                        cnt_d   = '0;
                        state_d = RD_BURST;
                    end
                end
            end
            WR_DATA: begin
                if (hs) begin
                    ram_we = 1'b1;
                    cnt_d  = cnt_q + 32'd1;
                    if (cnt_q == size_q - 32'd1) state_d = WR_ACK;
                end
            end
            WR_ACK: begin
                if (!fifo_full) begin
                    ack_push = 1'b1;
                    state_d  = IDLE;
                end
            end
            RD_BURST: begin
                // Count the read still in the RAM pipeline so its push always has a slot.
                if (free_slots > (RW+1)'(rd_valid_q)) begin
                    ram_re    = 1'b1;
                    cnt_d     = cnt_q + 32'd1;
                    rd_last_d = (cnt_q == size_q - 32'd1);
                    if (rd_last_d) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            cnt_q      <= '0;
            alive_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            cnt_q      <= cnt_d;
            alive_q    <= 1'b1;
            rd_valid_q <= ram_re;
            rd_last_q  <= rd_last_d;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ram_we) ram_q[ram_waddr] <= bus_dataout;
        if (ram_re) rd_data_q <= ram_q[ram_raddr];
    end

    assign push      = ack_push || rd_valid_q;
    assign push_flag = ack_push ? 1'b1 : rd_last_q;
    assign push_data = ack_push ? '0 : rd_data_q;
    assign pop       = bus_rsp_read && (count_q != '0);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            fifo_flag_q <= '0;
        end else begin
            if (push) begin
                fifo_flag_q[wptr_q] <= push_flag;
                wptr_q              <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + (RW+1)'(push) - (RW+1)'(pop);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push) fifo_data_q[wptr_q] <= push_data;
    end

    assign bus_rsp_empty_n = (count_q != '0);
    assign bus_datain      = bus_rsp_empty_n ? fifo_data_q[rptr_q] : '0;
    assign bus_rsp_dout    = bus_rsp_empty_n && fifo_flag_q[rptr_q];

`ifdef BUS_MEM_RESPONDER_STATS_EN
    logic [RSP_DEPTH-1:0] fifo_rd_q;
    logic [31:0]          stat_rd_q, stat_wr_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            fifo_rd_q <= '0;
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else begin
            if (push) fifo_rd_q[wptr_q] <= !ack_push;
            if (pop && fifo_rd_q[rptr_q]) stat_rd_q <= stat_rd_q + 32'd1;
            if (hs && (state_q == WR_DATA || bus_req_din)) stat_wr_q <= stat_wr_q + 32'd1;
        end
    end

    assign stat_rd_beats = stat_rd_q;
    assign stat_wr_beats = stat_wr_q;
`endif

endmodule

// File: tb/tb_bus_mem_responder.sv
// Randomized scoreboard bench for bus_mem_responder against an array-based memory model.
module tb_bus_mem_responder;

    localparam int DW    = 128;
    localparam int DEPTH = 256;
    localparam int RSPD  = 4;

    typedef struct packed {
        logic          flag;
        logic [DW-1:0] data;
    } exp_t;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          bus_req_din = 1'b0;
    logic          bus_req_write = 1'b0;
    logic          bus_req_full_n;
    logic [31:0]   bus_address = '0;
    logic [31:0]   bus_size = '0;
    logic [DW-1:0] bus_dataout = '0;
    logic [DW-1:0] bus_datain;
    logic          bus_rsp_empty_n;
    logic          bus_rsp_dout;
    logic          bus_rsp_read = 1'b0;
`ifdef BUS_MEM_RESPONDER_STATS_EN
    logic [31:0]   stat_rd_beats, stat_wr_beats;
`endif

    bus_mem_responder #(.DATA_W(DW), .DEPTH(DEPTH), .RSP_DEPTH(RSPD)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .bus_req_din(bus_req_din), .bus_req_write(bus_req_write), .bus_req_full_n(bus_req_full_n),
        .bus_address(bus_address), .bus_size(bus_size), .bus_dataout(bus_dataout),
        .bus_datain(bus_datain), .bus_rsp_empty_n(bus_rsp_empty_n), .bus_rsp_dout(bus_rsp_dout),
        .bus_rsp_read(bus_rsp_read)
`ifdef BUS_MEM_RESPONDER_STATS_EN
        , .stat_rd_beats(stat_rd_beats), .stat_wr_beats(stat_wr_beats)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    int            tests = 0;
    int            fails = 0;
    int            pops = 0;
    int            rd_mode = 0;      // 0 always pop, 1 toggle, 2 random, 3 hold off
    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] wd_q[$];
    logic [DW-1:0] mem_m [DEPTH];

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge ap_clk) begin
        #1;
        case (rd_mode)
            0:       bus_rsp_read = 1'b1;
            1:       bus_rsp_read = ~bus_rsp_read;
            2:       bus_rsp_read = 1'($urandom_range(0, 1));
            default: bus_rsp_read = 1'b0;
        endcase
    end

    always @(negedge ap_clk) begin
        if (ap_rst_n && bus_rsp_empty_n && bus_rsp_read) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got %h expected no response", {bus_rsp_dout, bus_datain});
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp", {bus_rsp_dout, bus_datain}, {mon_e.flag, mon_e.data});
            end
            pops++;
        end
    end

    task automatic handshake();
        int unsigned n = 0;
        bit ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge ap_clk);
            ok = bus_req_full_n;
            @(posedge ap_clk);
            n++;
        end
        #1;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL handshake_timeout: got full_n=0 for %0d cycles expected 1", n);
        end
    endtask

    task automatic send_req(input bit wr, input logic [31:0] addr, input int unsigned size, input bit gaps);
        int unsigned beats = (size == 0) ? 1 : size;
        int w = int'(addr[11:4]);
        logic [DW-1:0] d;
        d = (wd_q.size() != 0) ? wd_q.pop_front() : rnd128();
        bus_req_write = 1'b1;
        bus_req_din   = wr;
        bus_address   = addr;
        bus_size      = size;
        bus_dataout   = wr ? d : '0;
        handshake();
        if (!wr) begin
            bus_req_write = 1'b0;
            for (int unsigned k = 0; k < beats; k++)
                exp_q.push_back('{flag: (k == beats - 1), data: mem_m[(w + int'(k)) % DEPTH]});
            return;
        end
        mem_m[w] = d;
        for (int unsigned k = 1; k < beats; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus_req_write = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge ap_clk);
                #1;
            end
            d = (wd_q.size() != 0) ? wd_q.pop_front() : rnd128();
            bus_req_write = 1'b1;
            bus_req_din   = 1'($urandom_range(0, 1));
            bus_address   = $urandom;
            bus_size      = $urandom;
            bus_dataout   = d;
            handshake();
            mem_m[(w + int'(k)) % DEPTH] = d;
        end
        bus_req_write = 1'b0;
        exp_q.push_back('{flag: 1'b1, data: '0});
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge ap_clk);
            n++;
        end
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        #2;
        ap_rst_n      = 1'b0;
        bus_req_write = 1'b0;
        #1;
        check("rst_empty_n", {{DW{1'b0}}, bus_rsp_empty_n}, '0);
        check("rst_datain",  {1'b0, bus_datain}, '0);
        check("rst_full_n",  {{DW{1'b0}}, bus_req_full_n}, '0);
        exp_q.delete();
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        check("post_rst_full_n", {{DW{1'b0}}, bus_req_full_n}, {{DW{1'b0}}, 1'b1});
`ifdef BUS_MEM_RESPONDER_STATS_EN
        check("rst_stat_rd", {{(DW-31){1'b0}}, stat_rd_beats}, '0);
`endif
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion expected $finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int n;
        #12;
        check("init_empty_n", {{DW{1'b0}}, bus_rsp_empty_n}, '0);
        check("init_full_n",  {{DW{1'b0}}, bus_req_full_n}, '0);
        check("init_datain",  {1'b0, bus_datain}, '0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        check("init_post_full_n", {{DW{1'b0}}, bus_req_full_n}, {{DW{1'b0}}, 1'b1});

        rd_mode = 0;
        for (int i = 0; i < 4; i++) send_req(1'b1, 32'(i * 64 * 16), 64, 1'b0);
        wait_drain();

        // Single write, then single read with the latency checked by cycle.
        wd_q.push_back(128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF);
        send_req(1'b1, 32'h40, 1, 1'b0);
        wait_drain();
        rd_mode = 3;
        repeat (3) @(posedge ap_clk);
        #1;
        send_req(1'b0, 32'h40, 1, 1'b0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        check("lat_t1_empty_n", {{DW{1'b0}}, bus_rsp_empty_n}, '0);
        @(negedge ap_clk);
        check("lat_t2_empty_n", {{DW{1'b0}}, bus_rsp_empty_n}, {{DW{1'b0}}, 1'b1});
        check("lat_t2_head", {bus_rsp_dout, bus_datain}, {1'b1, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF});
        rd_mode = 0;
        wait_drain();

        for (int i = 1; i <= 8; i++) wd_q.push_back(DW'(i));
        send_req(1'b1, 32'h100, 8, 1'b1);
        wait_drain();
        rd_mode = 1;
        send_req(1'b0, 32'h100, 8, 1'b0);
        wait_drain();

        rd_mode = 0;
        for (int i = 1; i <= 4; i++) wd_q.push_back(DW'(i + 2));
        send_req(1'b1, 32'hFE0, 4, 1'b0);
        send_req(1'b0, 32'h0, 4, 1'b0);
        wait_drain();

        rd_mode = 3;
        repeat (3) @(posedge ap_clk);
        #1;
        send_req(1'b0, 32'h200, 16, 1'b0);
        repeat (20) @(negedge ap_clk);
        check("full_req_full_n", {{DW{1'b0}}, bus_req_full_n}, '0);
        check("full_empty_n", {{DW{1'b0}}, bus_rsp_empty_n}, {{DW{1'b0}}, 1'b1});
        rd_mode = 0;
        wait_drain();

        p0 = pops;
        send_req(1'b0, 32'h300, 8, 1'b0);
        n = 0;
        while (pops < p0 + 3 && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        do_reset();
        send_req(1'b0, 32'h300, 3, 1'b0);
        wait_drain();

        rd_mode = 2;
        for (int i = 0; i < 30; i++)
            send_req(1'($urandom_range(0, 1)), $urandom & 32'hFFFF, $urandom_range(0, 12), 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
